txlogic_handle: RTL and testbench



---
 rtl/uart_pkg.sv | 24 ++
 rtl/txlogic_handle.sv | 173 +++++++++++++++++
 tb/tb_txlogic_handle.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART transmit-side digit handler.
//   tx_state_t  : frame FSM states (TERM_CR/TERM_LF are used only when
//                 TXLOGIC_CRLF_EN is defined)
//   ASCII_*     : byte constants used for idle/clear values and line terminators
//   NUM_DIGITS  : digit bytes per frame (fixed; index is 3 bits)
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    TERM_CR,
    TERM_LF,
    DONE
  } tx_state_t;

  localparam logic [7:0]  ASCII_ZERO = 8'h30;
  localparam logic [7:0]  ASCII_CR   = 8'h0D;
  localparam logic [7:0]  ASCII_LF   = 8'h0A;
  localparam int unsigned NUM_DIGITS = 8;

  // Index of the first digit sent (digit7); also the idle/wrap value of the index.
  localparam logic [2:0]  LAST_INDEX = 3'(NUM_DIGITS - 1);

endpackage

// File: rtl/txlogic_handle.sv
// txlogic_handle: snapshots eight ASCII digit registers on a start request and
// streams them, digit7 first, into a UART TX byte interface (valid/ready).
//
// Ports:
//   clk            system clock, rising edge
//   rstp           asynchronous active-high reset
//   start          single-cycle frame request, honoured only in IDLE
//   digit0..digit7 ASCII bytes, captured when start is accepted
//   t_ready        TX core accepts a byte this cycle
//   t_data         byte offered to the TX core (registered)
//   t_valid        t_data is valid (registered)
//   busy           frame in progress
//   done           one-cycle pulse after the last byte is accepted
//
// Build option: define TXLOGIC_CRLF_EN to append CR, LF after digit0
// (10-byte frame). Without it the frame is the 8 digit bytes only.
module txlogic_handle
  import uart_pkg::*;
#(
  parameter logic [7:0] IDLE_CHAR = ASCII_ZERO
) (
  input  logic       clk,
  input  logic       rstp,
  input  logic       start,
  input  logic [7:0] digit0,
  input  logic [7:0] digit1,
  input  logic [7:0] digit2,
  input  logic [7:0] digit3,
  input  logic [7:0] digit4,
  input  logic [7:0] digit5,
  input  logic [7:0] digit6,
  input  logic [7:0] digit7,
  input  logic       t_ready,
  output logic [7:0] t_data,
  output logic       t_valid,
  output logic       busy,
  output logic       done
);

  logic [7:0] w_digits [NUM_DIGITS];

  assign w_digits[0] = digit0;
  assign w_digits[1] = digit1;
  assign w_digits[2] = digit2;
  assign w_digits[3] = digit3;
  assign w_digits[4] = digit4;
  assign w_digits[5] = digit5;
  assign w_digits[6] = digit6;
  assign w_digits[7] = digit7;

  tx_state_t  r_state,   w_state_nxt;
  logic [2:0] r_index,   w_index_nxt;
  logic [7:0] r_t_data,  w_t_data_nxt;
  logic       r_t_valid, w_t_valid_nxt;
  logic       r_busy,    w_busy_nxt;
  logic       r_done,    w_done_nxt;
  logic [7:0] r_shadow [NUM_DIGITS];
  logic       w_load;
  logic       w_xfer;

  // A byte moves on any edge where the offered byte is accepted.
  assign w_xfer = r_t_valid & t_ready;

  always_comb begin
    w_state_nxt   = r_state;
    w_index_nxt   = r_index;
    w_t_data_nxt  = r_t_data;
    w_t_valid_nxt = r_t_valid;
    w_busy_nxt    = r_busy;
    w_done_nxt    = 1'b0;
    w_load        = 1'b0;

    case (r_state)
      IDLE: begin
        if (start) begin
          w_load        = 1'b1;
          w_index_nxt   = LAST_INDEX;
          w_busy_nxt    = 1'b1;
          w_t_valid_nxt = 1'b1;
          // Shadow7 is being loaded this same edge, so offer the input directly.
          w_t_data_nxt  = w_digits[NUM_DIGITS-1];
          w_state_nxt   = SEND;
        end
      end

      SEND: begin
        if (w_xfer) begin
          if (r_index == 3'd0) begin
            w_index_nxt = LAST_INDEX;
`ifdef TXLOGIC_CRLF_EN
            w_t_data_nxt = ASCII_CR;
            w_state_nxt  = TERM_CR;
`else
            w_t_valid_nxt = 1'b0;
            w_busy_nxt    = 1'b0;
            w_done_nxt    = 1'b1;
            w_state_nxt   = DONE;
`endif
          end else begin
            w_index_nxt  = r_index - 3'd1;
            w_t_data_nxt = r_shadow[r_index - 3'd1];
          end
        end
      end

`ifdef TXLOGIC_CRLF_EN
      TERM_CR: begin
        if (w_xfer) begin
          w_t_data_nxt = ASCII_LF;
          w_state_nxt  = TERM_LF;
        end
      end

      TERM_LF: begin
        if (w_xfer) begin
          w_t_valid_nxt = 1'b0;
          w_busy_nxt    = 1'b0;
          w_done_nxt    = 1'b1;
          w_state_nxt   = DONE;
        end
      end
`endif

      // start is deliberately not looked at here.
      DONE: begin
        w_state_nxt = IDLE;
      end

      default: begin
        w_state_nxt   = IDLE;
        w_t_valid_nxt = 1'b0;
        w_busy_nxt    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rstp) begin
    if (rstp) begin
      r_state   <= IDLE;
      r_index   <= LAST_INDEX;
      r_t_data  <= 8'h00;
      r_t_valid <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_index   <= w_index_nxt;
      r_t_data  <= w_t_data_nxt;
      r_t_valid <= w_t_valid_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
    end
  end

  // Shadow file only changes on an accepted start, so digit inputs may move mid-frame.
  always_ff @(posedge clk or posedge rstp) begin
    if (rstp) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        r_shadow[i] <= IDLE_CHAR;
      end
    end else if (w_load) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        r_shadow[i] <= w_digits[i];
      end
    end
  end

  assign t_data  = r_t_data;
  assign t_valid = r_t_valid;
  assign busy    = r_busy;
  assign done    = r_done;

endmodule

// File: tb/tb_txlogic_handle.sv
// tb_txlogic_handle: self-checking bench for txlogic_handle. A queue-based model
// (pending frame bytes, busy/done flags) predicts outputs every cycle; directed
// frames pin the model with literal byte sequences, then random traffic follows.
// Honours TXLOGIC_CRLF_EN for the expected frame length and terminators.
module tb_txlogic_handle;
  import uart_pkg::*;

`ifdef TXLOGIC_CRLF_EN
  localparam int FrameLen = 10;
`else
  localparam int FrameLen = 8;
`endif

  logic       clk = 1'b0;
  logic       rstp;
  logic       start;
  logic       t_ready;
  logic [7:0] dig [8];
  logic [7:0] t_data;
  logic       t_valid;
  logic       busy;
  logic       done;

  always #5 clk = ~clk;

  txlogic_handle dut (
    .clk     (clk),
    .rstp    (rstp),
    .start   (start),
    .digit0  (dig[0]),
    .digit1  (dig[1]),
    .digit2  (dig[2]),
    .digit3  (dig[3]),
    .digit4  (dig[4]),
    .digit5  (dig[5]),
    .digit6  (dig[6]),
    .digit7  (dig[7]),
    .t_ready (t_ready),
    .t_data  (t_data),
    .t_valid (t_valid),
    .busy    (busy),
    .done    (done)
  );

  int checks = 0;
  int errors = 0;

  // Model: bytes still to send (head is on the wire), frame-active flag, done pulse.
  logic [7:0] m_q [$];
  bit         m_busy;
  bit         m_done;

  // Observed DUT activity (actuals only).
  logic [7:0] dut_tx [$];
  int         done_cnt;
  int         valid_cycles;
  logic       s_valid;
  logic [7:0] s_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_busy  = 0;
    m_done  = 0;
    s_valid = 1'b0;
  endtask

  // Called just after a rising edge, with the inputs that were present at it.
  task automatic model_step();
    if (rstp) begin
      model_reset();
      return;
    end
    if (s_valid && t_ready) dut_tx.push_back(s_data);
    if (m_done) begin
      m_done = 0;
    end else if (!m_busy) begin
      if (start) begin
        m_q.delete();
        for (int i = 7; i >= 0; i--) m_q.push_back(dig[i]);
`ifdef TXLOGIC_CRLF_EN
        m_q.push_back(8'h0D);
        m_q.push_back(8'h0A);
`endif
        m_busy = 1;
      end
    end else if (t_ready) begin
      void'(m_q.pop_front());
      if (m_q.size() == 0) begin
        m_busy = 0;
        m_done = 1;
      end
    end
  endtask

  task automatic compare();
    check("t_valid", 32'(t_valid), 32'(m_busy));
    check("busy", 32'(busy), 32'(m_busy));
    check("done", 32'(done), 32'(m_done));
    if (m_busy && m_q.size() > 0) check("t_data", 32'(t_data), 32'(m_q[0]));
    s_valid = t_valid;
    s_data  = t_data;
    if (done === 1'b1) done_cnt++;
    if (t_valid === 1'b1) valid_cycles++;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  // digit7 = '1' ... digit0 = '8'
  task automatic set_basic_digits();
    for (int i = 0; i < 8; i++) dig[i] = 8'h31 + 8'(7 - i);
  endtask

  function automatic logic [7:0] basic_byte(input int i);
    if (i < 8) return 8'h31 + 8'(i);
    return (i == 8) ? 8'h0D : 8'h0A;
  endfunction

  task automatic pin_frame(input string name);
    check({name, "_len"}, 32'(dut_tx.size()), 32'(FrameLen));
    for (int i = 0; i < FrameLen && i < dut_tx.size(); i++)
      check({name, "_byte"}, 32'(dut_tx[i]), 32'(basic_byte(i)));
  endtask

  // One frame of the basic digits; optional stall on a given byte, optional
  // in-frame digit change and repeated start requests.
  task automatic send_frame(input string name, input int stall_at, input int stall_len,
                            input bit snap);
    int n;
    int stalled;
    dut_tx.delete();
    done_cnt     = 0;
    valid_cycles = 0;
    t_ready      = 1'b1;
    start        = 1'b1;
    tick();
    start = 1'b0;
    check({name, "_first_valid"}, 32'(t_valid), 32'd1);
    check({name, "_first_byte"}, 32'(t_data), 32'h31);
    n       = 0;
    stalled = 0;
    while ((m_busy || m_done) && n < 60) begin
      if (dut_tx.size() == stall_at && stalled < stall_len) begin
        t_ready = 1'b0;
        stalled++;
      end else begin
        t_ready = 1'b1;
      end
      start = snap && (n == 2 || n == 5 || n == 8);
      if (snap && n == 2) dig[7] = 8'h5A;
      tick();
      if (t_ready == 1'b0) begin
        check({name, "_stall_valid"}, 32'(t_valid), 32'd1);
        check({name, "_stall_data"}, 32'(t_data), 32'h33);
      end
      n++;
    end
    start   = 1'b0;
    t_ready = 1'b1;
    check({name, "_busy_end"}, 32'(busy), 32'd0);
    for (int i = 0; i < 3; i++) tick();
    pin_frame(name);
    check({name, "_done_cnt"}, 32'(done_cnt), 32'd1);
    if (stall_len == 0) check({name, "_valid_cycles"}, 32'(valid_cycles), 32'(FrameLen));
    set_basic_digits();
  endtask

  initial begin
    int n;
    rstp    = 1'b1;
    start   = 1'b0;
    t_ready = 1'b0;
    for (int i = 0; i < 8; i++) dig[i] = 8'h30;
    model_reset();
    done_cnt = 0;

    // Reset state
    for (int i = 0; i < 3; i++) tick();
    rstp = 1'b0;
    tick();
    check("rst_t_valid", 32'(t_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_t_data", 32'(t_data), 32'h00);

    set_basic_digits();
    send_frame("basic", -1, 0, 1'b0);
    send_frame("stall", 2, 3, 1'b0);
    send_frame("snap", -1, 0, 1'b1);

    // Reset after the 4th transfer
    dut_tx.delete();
    done_cnt = 0;
    t_ready  = 1'b1;
    start    = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (dut_tx.size() < 4 && n < 20) begin
      tick();
      n++;
    end
    check("midrst_reached", 32'(dut_tx.size()), 32'd4);
    #1;
    rstp = 1'b1;
    model_reset();
    #1;
    check("midrst_async_valid", 32'(t_valid), 32'd0);
    check("midrst_async_busy", 32'(busy), 32'd0);
    tick();
    tick();
    rstp = 1'b0;
    tick();
    check("midrst_no_done", 32'(done_cnt), 32'd0);
    send_frame("after_rst", -1, 0, 1'b0);

    // Random traffic
    for (int c = 0; c < 1500; c++) begin
      t_ready = ($urandom % 4) != 0;
      start   = ($urandom % 6) == 0;
      rstp    = ($urandom % 150) == 0;
      if (($urandom % 3) == 0)
        for (int i = 0; i < 8; i++) dig[i] = 8'($urandom_range(32, 126));
      tick();
    end
    rstp  = 1'b0;
    start = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
